rs232_avm_responder: RTL and testbench
======================================

# rs232_avm_responder

Avalon-MM slave that implements the byte-wide RS232 UART register map polled by the RSA wrapper's master: RX data at byte offset 0, TX data at 4, status at 8. It deserialises 8N1 frames from `uart_rxd` into a one-byte RX holding register and serialises bytes written to the TX holding register onto `uart_txd`. It sits between the Avalon fabric and the board UART pins, and serves as the bus-accurate partner model for wrapper simulation.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `avm_clk`  in  1  clock; all logic is on the rising edge.
- `avm_rst`  in  1  asynchronous, active-high reset.
- `avm_address`  in  5  byte address: 0 = RX, 4 = TX, 8 = STATUS; all others are unmapped.
- `avm_read`  in  1  read request.
- `avm_readdata`  out  32  registered read data.
- `avm_write`  in  1  write request.
- `avm_writedata`  in  32  write data; only [7:0] is used.
- `avm_waitrequest`  out  1  stall; the access completes in the cycle where this is low.
- `uart_rxd`  in  1  serial input, asynchronous to `avm_clk`; idle high.
- `uart_txd`  out  1  serial output; idle high.

## Operation
- **Handshake:** internal `ack_r`.
  - `avm_waitrequest = (avm_read | avm_write) & ~ack_r`.
  - `ack_r` sets in the first request cycle and clears in the next cycle, so every access costs exactly 2 cycles.
  - A request held high continuously is a sequence of separate 2-cycle accesses.
  - If read and write are both high, the read is performed and the write is ignored.
- **Read (ack cycle):** `avm_readdata` is loaded at the end of the cycle in which `avm_waitrequest` is low.
  - RX returns `{24'b0, rx_data}`.
  - STATUS returns: bit7 `rx_full`, bit6 `tx_empty`, bit3 `overrun`, bit2 `frame_err`, all other bits 0.
  - TX and unmapped addresses return 0.
  - Otherwise `avm_readdata` holds its value.
- **Read side effects:**
  - An RX read clears `rx_full`.
  - A STATUS read clears `overrun` and `frame_err`.
- **Write (ack cycle), address TX:**
  - If `tx_empty`: `tx_hold <= writedata[7:0]` and `tx_empty <= 0`.
  - If not `tx_empty`: the byte is dropped and no flag is raised.
  - Writes to RX, STATUS or unmapped addresses are ignored.
- **RX path:**
  - `uart_rxd` passes through a 2-FF synchroniser.
  - FSM: RX_IDLE → RX_START (on synced low) → RX_DATA → RX_STOP → RX_IDLE.
  - RX_START waits `CLKS_PER_BIT/2` cycles and re-samples. If the line is high, the start is treated as a glitch and the FSM returns to RX_IDLE.
  - RX_DATA samples 8 bits, LSB first, every `CLKS_PER_BIT` cycles at mid-bit.
  - RX_STOP samples at mid-stop, then outcomes are:
    - Stop high and `rx_full == 0`: `rx_data <= byte`, `rx_full <= 1`.
    - Stop high and `rx_full == 1`: `overrun <= 1`; the old `rx_data` is kept.
    - Stop low: `frame_err <= 1`; the byte is discarded.
  - The FSM returns to RX_IDLE immediately after the stop sample.
- **TX path:**
  - FSM: TX_IDLE → TX_START → TX_DATA → TX_STOP → TX_IDLE.
  - In TX_IDLE with `tx_empty == 0`: copy `tx_hold` to the shifter and set `tx_empty <= 1` in the same cycle.
  - Each bit lasts `CLKS_PER_BIT` cycles: start 0, then data LSB first, then stop 1.
  - A back-to-back held byte starts in the cycle after TX_STOP ends, with no extra idle bit.
- **Simultaneous events:**
  - RX frame completion in the same cycle as an RX-read ack: the new byte is stored and `rx_full` stays 1, with no overrun. The read returns the old byte.
  - Flag set in the same cycle as a STATUS-read clear: set wins.
  - TX write ack in the same cycle as the shifter taking `tx_hold`: impossible, because the write is accepted only when `tx_empty` was already 1.
- **Reset values:**
  - `avm_readdata = 0`, `ack_r = 0`, `uart_txd = 1`.
  - `rx_full = 0`, `tx_empty = 1`, `overrun = 0`, `frame_err = 0`.
  - Both FSMs go to IDLE and both synchroniser FFs go to 1.
  - Reset mid-frame aborts TX (the line goes high asynchronously) and discards a partial RX byte.

## Timing
- Every access completes in 2 cycles; read data is valid from the edge ending the ack cycle.
- TX latency: write ack in cycle N → `tx_hold` loaded at end of N → shifter loads in N+1 → `uart_txd` low from N+2 for `CLKS_PER_BIT` cycles.
  - Full frame = `10·CLKS_PER_BIT` cycles.
- RX latency: `rx_full` is set within 3 cycles after the mid-stop sample; the synchroniser adds 2 cycles of input delay.
- STATUS bit6 returns to 1 one cycle after the shifter load, so a second byte can be queued while the first is still shifting.

## Test plan
- **Reset with idle bus:** assert reset → `uart_txd = 1`; STATUS read returns `0x40`; `avm_waitrequest` is 0.
- **RX byte (`CLKS_PER_BIT = 16`):** drive frame `0xA5` on `uart_rxd` → STATUS returns `0xC0`; RX read returns `0x000000A5`; the following STATUS read returns `0x40`.
- **TX back-to-back:** write `0x3C`, then poll STATUS bit6 and write `0x81` → `uart_txd` carries frames `0x3C` then `0x81` contiguously, 160 cycles each.
- **Overrun:** receive `0x11` then `0x22` without reading → STATUS returns `0xC8`; RX returns `0x11`; the next STATUS read returns `0x40`.
- **Framing and glitch:** drive a stop bit low for `0x55` → STATUS bit2 = 1 and `rx_full = 0`. Then drive a 3-cycle low pulse → no frame is received and no flags change.
- **Reset mid-frame:** assert reset during TX bit 4 → `uart_txd` goes to 1 immediately; after release, STATUS returns `0x40` and the next write transmits correctly.

Source files
------------

// File: rtl/rs232_avm_responder.sv
// rs232_avm_responder: Avalon-MM view of a byte-wide 8N1 UART.
// Register map (byte offsets): 0 = RX data, 4 = TX data, 8 = STATUS.
// STATUS layout: [7] rx_full, [6] tx_empty, [3] overrun, [2] frame_err.
module rs232_avm_responder #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int             CW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [4:0]     ADDR_RX     = 5'd0;
    localparam logic [4:0]     ADDR_TX     = 5'd4;
    localparam logic [4:0]     ADDR_STATUS = 5'd8;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Handshake: a request (read or write high) is stalled by waitrequest in
    // its first cycle; ack_r rises and the access completes in the second
    // cycle, where waitrequest is low. ack_r then drops, so a request held
    // high turns into back-to-back 2-cycle accesses. Read beats write.
    logic ack_r;
    logic req;
    logic rd_ack;
    logic wr_ack;
    logic rx_rd_clr;
    logic st_rd_clr;
    logic tx_wr;

    logic [7:0] rx_data;
    logic       rx_full;
    logic       overrun;
    logic       frame_err;
    logic [7:0] tx_hold;
    logic       tx_empty;

    logic       rx_meta;
    logic       rx_sync;
    rx_state_t  rx_state;
    rx_state_t  rx_state_nxt;
    logic       rx_tick;
    logic       rx_done;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;

    tx_state_t  tx_state;
    tx_state_t  tx_state_nxt;
    logic       tx_tick;
    logic       tx_load;
    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;

    logic       unused_wdata;

    assign unused_wdata    = ^avm_writedata[31:8];
    assign req             = avm_read | avm_write;
    assign avm_waitrequest = req & ~ack_r;
    assign rd_ack          = avm_read & ack_r;
    assign wr_ack          = avm_write & ~avm_read & ack_r;
    assign rx_rd_clr       = rd_ack & (avm_address == ADDR_RX);
    assign st_rd_clr       = rd_ack & (avm_address == ADDR_STATUS);
    assign tx_wr           = wr_ack & (avm_address == ADDR_TX) & tx_empty;

    // Handshake acknowledge and registered read data.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            ack_r        <= 1'b0;
            avm_readdata <= 32'd0;
        end else begin
            ack_r <= req & ~ack_r;
            if (rd_ack) begin
                case (avm_address)
                    ADDR_RX:     avm_readdata <= {24'd0, rx_data};
                    ADDR_STATUS: avm_readdata <= {24'd0, rx_full, tx_empty, 2'b00,
                                                  overrun, frame_err, 2'b00};
                    default:     avm_readdata <= 32'd0;
                endcase
            end
        end
    end

    // Holding registers and flags; later assignments (sets) win over clears.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_data   <= 8'd0;
            rx_full   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            tx_hold   <= 8'd0;
            tx_empty  <= 1'b1;
        end else begin
            if (rx_rd_clr) rx_full <= 1'b0;
            if (st_rd_clr) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (rx_done) begin
                if (!rx_sync) begin
                    frame_err <= 1'b1;
                end else if (!rx_full || rx_rd_clr) begin
                    rx_data <= rx_shift;
                    rx_full <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (tx_load) begin
                tx_empty <= 1'b1;
            end else if (tx_wr) begin
                tx_hold  <= avm_writedata[7:0];
                tx_empty <= 1'b0;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rx_sync <= rx_meta;
        end
    end

    // RX state register.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) rx_state <= RX_IDLE;
        else         rx_state <= rx_state_nxt;
    end

    // RX next state; rx_tick marks the mid-bit sample point of each state.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_tick      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                rx_tick = (rx_cnt == HALF_LAST);
                if (rx_tick) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                rx_tick = (rx_cnt == BIT_LAST);
                if (rx_tick && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                rx_tick = (rx_cnt == BIT_LAST);
                if (rx_tick) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign rx_done = (rx_state == RX_STOP) & rx_tick;

    // RX bit timer and LSB-first deserialiser.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
            else                                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_IDLE) begin
                rx_bit <= 3'd0;
            end else if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // TX state register.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) tx_state <= TX_IDLE;
        else         tx_state <= tx_state_nxt;
    end

    // TX next state; a pending byte is taken in idle or straight after a stop bit.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_load      = 1'b0;
        tx_tick      = (tx_cnt == BIT_LAST);
        case (tx_state)
            TX_IDLE: begin
                tx_tick = 1'b0;
                if (!tx_empty) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (tx_tick && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_load      = 1'b1;
                        tx_state_nxt = TX_START;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX bit timer, shifter and registered serial output.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            uart_txd <= 1'b1;
        end else if (tx_load) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= tx_hold;
            uart_txd <= 1'b0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_tick) begin
                tx_cnt <= '0;
                case (tx_state)
                    TX_START: begin
                        uart_txd <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end
                    TX_DATA: begin
                        tx_bit <= tx_bit + 1'b1;
                        if (tx_bit == 3'd7) begin
                            uart_txd <= 1'b1;
                        end else begin
                            uart_txd <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end
                    default: uart_txd <= 1'b1;
                endcase
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rs232_avm_responder.sv
// Directed bench for rs232_avm_responder with CLKS_PER_BIT = 16.
module tb_rs232_avm_responder;

    localparam int CPB = 16;

    logic        avm_clk;
    logic        avm_rst;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        uart_rxd;
    logic        uart_txd;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mon_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_q[$];
    int         mon_t[$];

    rs232_avm_responder #(.CLKS_PER_BIT(CPB)) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    // Clock and cycle counter.
    initial avm_clk = 1'b0;
    always #5 avm_clk = ~avm_clk;
    always @(posedge avm_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge avm_clk);
        #1;
    endtask

    // Bus read; starts and ends 1 ns after a rising edge.
    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        int waits;
        waits = 0;
        avm_address = a;
        avm_read    = 1'b1;
        #1;
        while (avm_waitrequest === 1'b1 && waits < 8) begin
            @(posedge avm_clk);
            #1;
            waits++;
        end
        check("rd_wait_cycles", 32'(waits), 32'd1);
        @(posedge avm_clk);
        #1;
        avm_read = 1'b0;
        d = avm_readdata;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        int waits;
        waits = 0;
        avm_address   = a;
        avm_writedata = d;
        avm_write     = 1'b1;
        #1;
        while (avm_waitrequest === 1'b1 && waits < 8) begin
            @(posedge avm_clk);
            #1;
            waits++;
        end
        check("wr_wait_cycles", 32'(waits), 32'd1);
        @(posedge avm_clk);
        #1;
        avm_write = 1'b0;
    endtask

    // Drives one 8N1 frame with a selectable stop level; line left high.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            idle(CPB);
        end
        uart_rxd = stop;
        idle(CPB);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int limit);
        int k;
        k = 0;
        while (mon_q.size() < n && k < limit) begin
            @(posedge avm_clk);
            k++;
        end
        #1;
        check("tx_frame_timeout", 32'(mon_q.size()), 32'(n));
    endtask

    // Serial monitor: decodes uart_txd frames sampled mid-bit on falling edges.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       ok;
        int         t0;
        forever begin
            @(negedge avm_clk);
            if (avm_rst === 1'b0 && uart_txd === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                b  = 8'h00;
                for (int k = 1; k <= 9 * CPB + CPB / 2; k++) begin
                    @(negedge avm_clk);
                    if (avm_rst !== 1'b0) begin
                        ok = 1'b0;
                        break;
                    end
                    if (k == CPB / 2 && uart_txd !== 1'b0) mon_bad++;
                    if (k > CPB && k < 9 * CPB && (k % CPB) == CPB / 2) b = {uart_txd, b[7:1]};
                    if (k == 9 * CPB + CPB / 2 && uart_txd !== 1'b1) mon_bad++;
                end
                if (ok) begin
                    mon_q.push_back(b);
                    mon_t.push_back(t0);
                end
            end
        end
    end

    // Directed stimulus sequence.
    initial begin : stim
        logic [31:0] d;
        int          wr_cyc;
        avm_rst       = 1'b1;
        avm_address   = 5'd0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = 32'd0;
        uart_rxd      = 1'b1;
        #2;
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_readdata", avm_readdata, 32'd0);
        check("rst_waitreq", {31'd0, avm_waitrequest}, 32'd0);
        idle(3);
        avm_rst = 1'b0;
        idle(2);

        // Reset state over the bus.
        check("idle_txd", {31'd0, uart_txd}, 32'd1);
        bus_read(5'd8, d);
        check("reset_status", d, 32'h40);
        bus_read(5'd4, d);
        check("tx_addr_reads_zero", d, 32'h0);
        bus_read(5'd8, d);
        bus_read(5'd12, d);
        check("unmapped_reads_zero", d, 32'h0);
        bus_write(5'd0, 32'hFF);
        bus_write(5'd8, 32'hFF);

        // RX of a single byte.
        send_frame(8'hA5, 1'b1);
        idle(4);
        bus_read(5'd8, d);
        check("rx_status_full", d, 32'hC0);
        bus_read(5'd0, d);
        check("rx_data_a5", d, 32'h0000_00A5);
        bus_read(5'd8, d);
        check("rx_status_cleared", d, 32'h40);
        check("no_tx_from_bad_addr_write", 32'(mon_q.size()), 32'd0);

        // Back-to-back TX; third write lands while holding is full and is dropped.
        bus_write(5'd4, 32'h3C);
        wr_cyc = cyc;
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 10; i++) begin
            bus_read(5'd8, d);
            if (d[6]) break;
        end
        check("tx_empty_after_load", {31'd0, d[6]}, 32'd1);
        bus_write(5'd4, 32'hFFFF_FF81);
        exp_q.push_back(8'h81);
        bus_read(5'd8, d);
        check("tx_status_holding", d, 32'h00);
        bus_write(5'd4, 32'h99);
        wait_frames(2, 400);
        idle(200);
        check("tx_frame_count", 32'(mon_q.size()), 32'd2);
        if (mon_t.size() == 2) begin
            check("tx_start_latency", 32'(mon_t[0] - wr_cyc), 32'd1);
            check("tx_back_to_back", 32'(mon_t[1] - mon_t[0]), 32'(10 * CPB));
        end
        while (exp_q.size() > 0 && mon_q.size() > 0)
            check("tx_byte", {24'd0, mon_q.pop_front()}, {24'd0, exp_q.pop_front()});
        check("tx_exp_left", 32'(exp_q.size()), 32'd0);
        bus_read(5'd8, d);
        check("tx_status_done", d, 32'h40);

        // Overrun.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        bus_read(5'd8, d);
        check("ovr_status", d, 32'hC8);
        bus_read(5'd0, d);
        check("ovr_rx_keeps_first", d, 32'h11);
        bus_read(5'd8, d);
        check("ovr_status_cleared", d, 32'h40);

        // Framing error, then a start-bit glitch.
        send_frame(8'h55, 1'b0);
        idle(30);
        bus_read(5'd8, d);
        check("frame_err_status", d, 32'h44);
        bus_read(5'd8, d);
        check("frame_err_cleared", d, 32'h40);
        uart_rxd = 1'b0;
        idle(3);
        uart_rxd = 1'b1;
        idle(40);
        bus_read(5'd8, d);
        check("glitch_status", d, 32'h40);
        bus_read(5'd0, d);
        check("glitch_rx_data", d, 32'h11);

        // Reset during TX bit 4 of 0xA5 (bit 4 = 0).
        mon_q.delete();
        mon_t.delete();
        bus_write(5'd4, 32'hA5);
        idle(88);
        check("txd_bit4_low", {31'd0, uart_txd}, 32'd0);
        avm_rst = 1'b1;
        #1;
        check("txd_async_reset", {31'd0, uart_txd}, 32'd1);
        idle(3);
        avm_rst = 1'b0;
        check("readdata_after_reset", avm_readdata, 32'd0);
        bus_read(5'd8, d);
        check("status_after_reset", d, 32'h40);
        bus_write(5'd4, 32'hC3);
        exp_q.push_back(8'hC3);
        wait_frames(1, 300);
        idle(20);
        check("post_reset_frames", 32'(mon_q.size()), 32'd1);
        while (exp_q.size() > 0 && mon_q.size() > 0)
            check("post_reset_byte", {24'd0, mon_q.pop_front()}, {24'd0, exp_q.pop_front()});
        check("tx_frame_shape", 32'(mon_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
